// File: rtl/magic_pkg.sv
// ---------------------------------------------------------------------------
// magic_pkg
// Shared types and constants for the 3x3 magic-square loader and the
// combinational checkers (isUnique, sumt, sum3, BCDOneDigitAdd) it feeds.
//
// Contents:
//   loader_state_t    : loader FSM states LOAD / FULL / ERROR
//   N_CELLS           : number of grid cells (3x3)
//   DEFAULT_MAX_DIGIT : largest legal BCD digit
//   cell_t            : one grid cell (one BCD digit)
// ---------------------------------------------------------------------------
package magic_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FULL  = 2'd1,
        ERROR = 2'd2
    } loader_state_t;

    localparam int N_CELLS           = 9;
    localparam int DEFAULT_MAX_DIGIT = 9;

    typedef logic [3:0] cell_t;

endpackage

// File: rtl/magic_square_loader.sv
// ---------------------------------------------------------------------------
// magic_square_loader
// Serial-to-parallel front end for the 3x3 magic-square checkers. Takes one
// BCD digit per cycle over a valid/ready handshake, fills num1..num9 in
// row-major order, then presents the grid with grid_valid until grid_ack.
// Non-BCD digits send the loader to a sticky ERROR state until clear.
//
// Optional build macro:
//   DUP_REJECT_EN : when defined, a 10-bit seen mask rejects a digit that is
//                   already in the grid (goes to ERROR), so a full grid is
//                   always unique. When undefined, duplicates load normally.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_L      in   asynchronous active-low reset
//   digit_in     in   next cell value
//   digit_valid  in   digit_in is valid this cycle
//   digit_ready  out  loader accepts a digit this cycle (state == LOAD)
//   clear        in   synchronous abort back to an empty LOAD
//   grid_ack     in   downstream has consumed the presented grid
//   num1..num9   out  grid cells, num1 top-left, num9 bottom-right
//   grid_valid   out  all nine cells loaded and stable
//   bad_digit    out  sticky error flag
//   count        out  cells loaded so far, 0..9
// ---------------------------------------------------------------------------
module magic_square_loader
    import magic_pkg::*;
#(
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = DEFAULT_MAX_DIGIT
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic               clear,
    input  logic               grid_ack,
    output logic [DIGIT_W-1:0] num1,
    output logic [DIGIT_W-1:0] num2,
    output logic [DIGIT_W-1:0] num3,
    output logic [DIGIT_W-1:0] num4,
    output logic [DIGIT_W-1:0] num5,
    output logic [DIGIT_W-1:0] num6,
    output logic [DIGIT_W-1:0] num7,
    output logic [DIGIT_W-1:0] num8,
    output logic [DIGIT_W-1:0] num9,
    output logic               grid_valid,
    output logic               bad_digit,
    output logic [3:0]         count
);

    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

    loader_state_t      r_state;
    loader_state_t      w_nextState;
    logic [DIGIT_W-1:0] r_cells [N_CELLS];
    logic [3:0]         r_count;
    logic               r_gridValid;
    logic               r_badDigit;
    logic               w_accept;
    logic               w_legal;
    logic               w_dup;
    logic               w_store;
    logic               w_wipe;

`ifdef DUP_REJECT_EN
    logic [9:0]         r_seen;
`endif

    // A digit is only taken while loading; FULL and ERROR stall upstream.
    assign w_accept = digit_valid && (r_state == LOAD);
    assign w_legal  = (digit_in <= MAX_D);

    // Duplicate detection compares against each of the ten BCD values so
    // an out-of-range digit never indexes past the seen mask.
`ifdef DUP_REJECT_EN
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (digit_in == DIGIT_W'(i) && r_seen[i]) begin
                w_dup = 1'b1;
            end
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // A cell is written only for a legal, non-duplicate accepted digit; clear
    // always wins, so a digit offered alongside clear is dropped.
    assign w_store = w_accept && w_legal && !w_dup && !clear;

    // The grid is emptied on clear or when a FULL grid is acknowledged.
    assign w_wipe  = clear || ((r_state == FULL) && grid_ack);

    // State register. grid_valid and bad_digit are registered copies of the
    // next state so every output except digit_ready comes straight off a flop.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= LOAD;
            r_gridValid <= 1'b0;
            r_badDigit  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_gridValid <= (w_nextState == FULL);
            r_badDigit  <= (w_nextState == ERROR);
        end
    end

    // Next-state logic. clear has top priority in every state; ERROR only
    // leaves on clear, and grid_ack matters only in FULL.
    always_comb begin
        w_nextState = r_state;
        if (clear) begin
            w_nextState = LOAD;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (!w_legal || w_dup) begin
                            w_nextState = ERROR;
                        end else if (r_count == 4'd8) begin
                            w_nextState = FULL;
                        end
                    end
                end
                FULL: begin
                    if (grid_ack) begin
                        w_nextState = LOAD;
                    end
                end
                ERROR: begin
                    w_nextState = ERROR;
                end
                default: begin
                    w_nextState = LOAD;
                end
            endcase
        end
    end

    // Output logic: ready is the only combinational output.
    always_comb begin
        digit_ready = (r_state == LOAD);
        grid_valid  = r_gridValid;
        bad_digit   = r_badDigit;
        count       = r_count;
        num1        = r_cells[0];
        num2        = r_cells[1];
        num3        = r_cells[2];
        num4        = r_cells[3];
        num5        = r_cells[4];
        num6        = r_cells[5];
        num7        = r_cells[6];
        num8        = r_cells[7];
        num9        = r_cells[8];
    end

    // Cell storage and fill counter. The write slot is selected by comparing
    // count against each index; count never passes 8 while storing, since
    // the ninth store moves the FSM to FULL.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= 4'd0;
            for (int i = 0; i < N_CELLS; i++) begin
                r_cells[i] <= '0;
            end
        end else if (w_wipe) begin
            r_count <= 4'd0;
            for (int i = 0; i < N_CELLS; i++) begin
                r_cells[i] <= '0;
            end
        end else if (w_store) begin
            r_count <= r_count + 4'd1;
            for (int i = 0; i < N_CELLS; i++) begin
                if (r_count == 4'(i)) begin
                    r_cells[i] <= digit_in;
                end
            end
        end
    end

`ifdef DUP_REJECT_EN
    // Seen mask follows the cells: set on store, emptied with the grid.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_seen <= '0;
        end else if (w_wipe) begin
            r_seen <= '0;
        end else if (w_store) begin
            for (int i = 0; i < 10; i++) begin
                if (digit_in == DIGIT_W'(i)) begin
                    r_seen[i] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_magic_square_loader.sv
// ---------------------------------------------------------------------------
// tb_magic_square_loader
// Directed bench for magic_square_loader: loads known magic squares, holds
// a FULL grid under upstream pressure, exercises the bad-digit error path,
// duplicate handling (DUP_REJECT_EN aware), asynchronous reset mid-load and
// clear colliding with a digit offer.
// ---------------------------------------------------------------------------
module tb_magic_square_loader;

    logic       clock;
    logic       reset_L;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       clear;
    logic       grid_ack;
    logic [3:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
    logic       grid_valid;
    logic       bad_digit;
    logic [3:0] count;

    int total;
    int bad;

    int gridA [9] = '{2, 7, 6, 9, 5, 1, 4, 3, 8};
    int gridB [9] = '{6, 1, 8, 7, 5, 3, 2, 9, 4};

    magic_square_loader #(
        .DIGIT_W   (4),
        .MAX_DIGIT (9)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .clear       (clear),
        .grid_ack    (grid_ack),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .num4        (num4),
        .num5        (num5),
        .num6        (num6),
        .num7        (num7),
        .num8        (num8),
        .num9        (num9),
        .grid_valid  (grid_valid),
        .bad_digit   (bad_digit),
        .count       (count)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed cell i (0-based, row-major).
    function automatic logic [3:0] cellAt(input int i);
        case (i)
            0: return num1;
            1: return num2;
            2: return num3;
            3: return num4;
            4: return num5;
            5: return num6;
            6: return num7;
            7: return num8;
            default: return num9;
        endcase
    endfunction

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_L     = 1'b0;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        grid_ack    = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_ready", 32'(digit_ready), 32'd1);
        checkOutput("rst_gv", 32'(grid_valid), 32'd0);
        checkOutput("rst_bad", 32'(bad_digit), 32'd0);
        checkOutput("rst_num1", 32'(num1), 32'd0);
        @(negedge clock);
        reset_L = 1'b1;
        applyStimulus();

        // Back-to-back load of the first magic square
        for (int i = 0; i < 9; i++) begin
            digit_valid = 1'b1;
            digit_in    = 4'(gridA[i]);
            checkOutput($sformatf("loadA_ready%0d", i), 32'(digit_ready), 32'd1);
            applyStimulus();
            checkOutput($sformatf("loadA_count%0d", i), 32'(count), 32'(i + 1));
        end
        checkOutput("fullA_gv", 32'(grid_valid), 32'd1);
        checkOutput("fullA_ready", 32'(digit_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("fullA_cell%0d", i), 32'(cellAt(i)), 32'(gridA[i]));
        end

        // FULL under continuous upstream pressure
        digit_in = 4'd3;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        checkOutput("hold_count", 32'(count), 32'd9);
        checkOutput("hold_gv", 32'(grid_valid), 32'd1);
        checkOutput("hold_num1", 32'(num1), 32'd2);
        checkOutput("hold_num9", 32'(num9), 32'd8);
        digit_valid = 1'b0;
        grid_ack    = 1'b1;
        applyStimulus();
        grid_ack = 1'b0;
        checkOutput("ack_count", 32'(count), 32'd0);
        checkOutput("ack_gv", 32'(grid_valid), 32'd0);
        checkOutput("ack_ready", 32'(digit_ready), 32'd1);
        checkOutput("ack_num5", 32'(num5), 32'd0);

        // Illegal digit: 6, 1, 12
        digit_valid = 1'b1;
        digit_in = 4'd6;  applyStimulus();
        digit_in = 4'd1;  applyStimulus();
        digit_in = 4'd12; applyStimulus();
        digit_valid = 1'b0;
        checkOutput("err_bad", 32'(bad_digit), 32'd1);
        checkOutput("err_count", 32'(count), 32'd2);
        checkOutput("err_num1", 32'(num1), 32'd6);
        checkOutput("err_num2", 32'(num2), 32'd1);
        checkOutput("err_num3", 32'(num3), 32'd0);
        checkOutput("err_ready", 32'(digit_ready), 32'd0);
        checkOutput("err_gv", 32'(grid_valid), 32'd0);
        grid_ack = 1'b1;
        applyStimulus();
        grid_ack = 1'b0;
        checkOutput("errack_bad", 32'(bad_digit), 32'd1);
        checkOutput("errack_count", 32'(count), 32'd2);
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        checkOutput("clr_bad", 32'(bad_digit), 32'd0);
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_num1", 32'(num1), 32'd0);
        checkOutput("clr_ready", 32'(digit_ready), 32'd1);

        // Duplicate digits 1, 1
        digit_valid = 1'b1;
        digit_in = 4'd1; applyStimulus();
        digit_in = 4'd1; applyStimulus();
        digit_valid = 1'b0;
`ifdef DUP_REJECT_EN
        checkOutput("dup_count", 32'(count), 32'd1);
        checkOutput("dup_bad", 32'(bad_digit), 32'd1);
`else
        checkOutput("dup_count", 32'(count), 32'd2);
        checkOutput("dup_bad", 32'(bad_digit), 32'd0);
        checkOutput("dup_num2", 32'(num2), 32'd1);
`endif
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;

        // Asynchronous reset after four digits
        digit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit_in = 4'(gridB[i]);
            applyStimulus();
        end
        digit_valid = 1'b0;
        checkOutput("pre_rst_count", 32'(count), 32'd4);
        #2;
        reset_L = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_num1", 32'(num1), 32'd0);
        checkOutput("arst_num4", 32'(num4), 32'd0);
        checkOutput("arst_ready", 32'(digit_ready), 32'd1);
        @(negedge clock);
        reset_L = 1'b1;

        // Fresh load of the second magic square
        digit_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            digit_in = 4'(gridB[i]);
            applyStimulus();
        end
        digit_valid = 1'b0;
        checkOutput("fullB_gv", 32'(grid_valid), 32'd1);
        checkOutput("fullB_count", 32'(count), 32'd9);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("fullB_cell%0d", i), 32'(cellAt(i)), 32'(gridB[i]));
        end
        grid_ack = 1'b1;
        applyStimulus();
        grid_ack = 1'b0;

        // clear collides with a digit offer at count 3
        digit_valid = 1'b1;
        digit_in = 4'd1; applyStimulus();
        digit_in = 4'd2; applyStimulus();
        digit_in = 4'd3; applyStimulus();
        checkOutput("pre_clr_count", 32'(count), 32'd3);
        clear    = 1'b1;
        digit_in = 4'd5;
        applyStimulus();
        clear       = 1'b0;
        digit_valid = 1'b0;
        checkOutput("clrdrop_count", 32'(count), 32'd0);
        checkOutput("clrdrop_num1", 32'(num1), 32'd0);
        checkOutput("clrdrop_num4", 32'(num4), 32'd0);
        checkOutput("clrdrop_ready", 32'(digit_ready), 32'd1);
        applyStimulus();
        checkOutput("idle_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magic_square_loader.md
Name: magic_square_loader

Overview:
- Serial-to-parallel front end for the combinational 3x3 magic-square checkers: isUnique, sumt, sum3 and BCDOneDigitAdd.
- Accepts one BCD digit per cycle over a valid/ready handshake and fills cells num1..num9 in row-major order.
- Holds the completed grid stable and flags it valid until downstream logic acknowledges it.
- Rejects non-BCD digits and latches an error until cleared.

Parameters:
- DIGIT_W, 4, width of each cell and of digit_in.
- MAX_DIGIT, 9, largest legal digit value; anything greater is an error.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_L  input  1  asynchronous, active-low reset
- digit_in  input  DIGIT_W  next cell value
- digit_valid  input  1  digit_in is valid this cycle
- digit_ready  output  1  loader can accept a digit this cycle
- clear  input  1  synchronous abort; return to empty LOAD
- grid_ack  input  1  downstream has consumed the presented grid
- num1..num9  output  DIGIT_W each  grid cells, row-major (num1 top-left, num9 bottom-right)
- grid_valid  output  1  all nine cells loaded and stable
- bad_digit  output  1  sticky error flag
- count  output  4  cells loaded so far, 0..9

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values while reset_L is low: state LOAD; count=0; num1..num9=0; grid_valid=0; bad_digit=0; digit_ready=1.
- States: LOAD, FULL, ERROR. All outputs are registered except digit_ready, which equals (state==LOAD).
- Accept: a digit is accepted when digit_valid && digit_ready at the rising edge.
- LOAD, accepted digit with digit_in <= MAX_DIGIT:
  - the cell at index count takes digit_in; count increments.
  - if count was 8, go to FULL; grid_valid=1 on the cycle after the 9th accept, so latency is 1 cycle.
- LOAD, accepted digit with digit_in > MAX_DIGIT:
  - no cell is written and count is held.
  - go to ERROR; bad_digit=1 the next cycle.
- FULL:
  - digit_ready=0; digit_valid is ignored.
  - cells are frozen and grid_valid=1.
  - on grid_ack, go to LOAD next cycle with count=0, all cells 0 and grid_valid=0.
- ERROR:
  - digit_ready=0 and grid_valid=0; partial cells are held for debug.
  - stays in ERROR until clear; grid_ack is ignored.
- grid_ack outside FULL has no effect.
- clear has highest priority in every state. The next cycle gives LOAD, count=0, all cells 0, grid_valid=0, bad_digit=0. A digit offered in the same cycle is dropped.
- Reset mid-load: everything returns to reset values immediately, asynchronously.
- count never exceeds 9 and has no wrap-around; FULL blocks further accepts.
- Upstream may hold digit_valid high continuously; one digit is consumed per ready cycle.

Optional Feature:
- Macro: DUP_REJECT_EN.
- Defined:
  - a 10-bit seen-mask register tracks digits already stored; it is reset and cleared with the cells.
  - an accepted legal digit whose seen bit is set goes to ERROR with bad_digit=1. The cell is not written and count is held.
  - a full grid is then guaranteed unique.
- Undefined: no seen mask; duplicates load normally and uniqueness is left to isUnique downstream.

Decomposition:
- Shared package magic_pkg:
  - loader_state_t enum {LOAD, FULL, ERROR}
  - N_CELLS=9
  - MAX_DIGIT default
  - cell_t typedef (logic [3:0])
- No sub-module is required. Cell storage is one 9-entry array indexed by count, mapped to num1..num9.

Test Plan:
- Reset, then feed 2,7,6,9,5,1,4,3,8 back-to-back:
  - digit_ready=1 throughout; count steps 1..9.
  - grid_valid=1 one cycle after the 9th accept, with num1..num9 = 2,7,6,9,5,1,4,3,8 and digit_ready=0.
  - the downstream isUnique and sumt checkers, driven from num1..num9, report unique_valid=1 and it_is_magic=1.
- Same grid FULL, hold digit_valid=1 with digit_in=3 for 5 cycles, then pulse grid_ack:
  - cells unchanged and grid_valid=1 until the ack.
  - the next cycle gives count=0, all cells 0, grid_valid=0, digit_ready=1.
- Feed 6,1,12:
  - bad_digit=1; count=2; num1=6, num2=1, num3=0; digit_ready=0.
  - grid_ack has no effect.
  - clear gives bad_digit=0 and count=0 the next cycle.
- Feed 1,1 with DUP_REJECT_EN defined: ERROR after the second 1, with count=1.
- Feed 1,1 without DUP_REJECT_EN: count=2, no error.
- Assert reset_L low after 4 digits, mid-load: all outputs return to 0 asynchronously. After release, a fresh 9-digit load of 6,1,8,7,5,3,2,9,4 completes correctly.
- Assert clear and digit_valid (digit_in=5) in the same cycle at count=3: count=0 and the digit is dropped.
